// File: rtl/csram_scheduler.sv
// Sweeps every CSRAM neuron word on a tick: read, hand to the neuron unit, write back the updated field.
// 4 cycles per neuron minimum plus one DONE cycle; the neuron unit stalls WAIT indefinitely, cfg writes only in IDLE.
module csram_scheduler #(
  parameter int NUM_NEURONS = 256,
  parameter int WIDTH       = 367,
  parameter int WRITE_INDEX = 102,
  parameter int WRITE_WIDTH = 9,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [WIDTH-1:0]       cfg_data,
  output logic                   neu_valid,
  output logic [AW-1:0]          neu_index,
  output logic [WIDTH-1:0]       neu_params,
  input  logic                   upd_valid,
  input  logic [WRITE_WIDTH-1:0] upd_field,
  output logic                   csram_wen,
  output logic [AW-1:0]          csram_address,
  output logic [WIDTH-1:0]       csram_data_in,
  input  logic [WIDTH-1:0]       csram_data_out,
  output logic                   sweep_done,
  output logic                   overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG_WR = 3'd1,
    RD     = 3'd2,
    LATCH  = 3'd3,
    WAIT   = 3'd4,
    WR     = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [AW-1:0]          idx;
  logic [AW-1:0]          idx_nxt;
  logic                   tick_pending;
  logic                   pending_nxt;
  logic [AW-1:0]          cfg_addr_q;
  logic [WIDTH-1:0]       cfg_data_q;
  logic [WIDTH-1:0]       param_q;
  logic [WRITE_WIDTH-1:0] field_q;
  logic [WIDTH-1:0]       wr_word;
  logic                   cfg_accept;
  logic                   last_idx;
  logic                   sweep_busy;

  assign cfg_accept = cfg_valid && cfg_ready;
  assign last_idx   = (idx == AW'(NUM_NEURONS - 1));
  assign sweep_busy = (state == RD) || (state == LATCH) || (state == WAIT) ||
                      (state == WR) || (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      tick_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      tick_pending <= pending_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pending_nxt = tick_pending;
    case (state)
      IDLE: begin
        if (cfg_accept) begin
          state_nxt = CFG_WR;
          if (tick) pending_nxt = 1'b1;
        end else if (tick || tick_pending) begin
          pending_nxt = 1'b0;
          idx_nxt     = '0;
          state_nxt   = RD;
        end
      end
      CFG_WR: begin
        if (tick || tick_pending) begin
          pending_nxt = 1'b0;
          idx_nxt     = '0;
          state_nxt   = RD;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD:    state_nxt = LATCH;
      LATCH: state_nxt = WAIT;
      WAIT:  if (upd_valid) state_nxt = WR;
      WR: begin
        if (last_idx) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + AW'(1);
          state_nxt = RD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath captures; cfg_ready is registered so it reads 0 while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      param_q    <= '0;
      field_q    <= '0;
      overrun    <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      if ((state == IDLE) && cfg_accept) begin
        cfg_addr_q <= cfg_addr;
        cfg_data_q <= cfg_data;
      end
      if (state == LATCH) param_q <= csram_data_out;
      if ((state == WAIT) && upd_valid) field_q <= upd_field;
      if (tick && sweep_busy) overrun <= 1'b1;
      cfg_ready <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    wr_word = param_q;
    wr_word[WRITE_INDEX +: WRITE_WIDTH] = field_q;
  end

  assign neu_index  = idx;
  assign neu_params = param_q;

  // Output decode.
  always_comb begin
    csram_wen     = 1'b0;
    csram_address = '0;
    csram_data_in = '0;
    neu_valid     = 1'b0;
    sweep_done    = 1'b0;
    case (state)
      CFG_WR: begin
        csram_wen     = 1'b1;
        csram_address = cfg_addr_q;
        csram_data_in = cfg_data_q;
      end
      RD, LATCH: csram_address = idx;
      WAIT: begin
        neu_valid     = 1'b1;
        csram_address = idx;
      end
      WR: begin
        csram_wen     = 1'b1;
        csram_address = idx;
        csram_data_in = wr_word;
      end
      DONE:    sweep_done = 1'b1;
      default: ;
    endcase
  end

endmodule
